udp_tx: RTL
===========

# udp_tx

UDP transmit encapsulator: accepts a UDP header (ports, length, checksum) on a valid/ready sideband and a payload on AXI-Stream, and emits one AXI-Stream frame with the 8-byte UDP header prepended, big-endian. It is the transmit-side counterpart of `udp_rx` and sits between the application payload source and the IP transmit block.

## Interface
- `AXI_DATA_WIDTH`, default 8: stream data width in bits; only 8 is supported.
- `i_clk` input 1: system clock, all logic on rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `s_udp_hdr_tvalid` input 1: header fields valid.
- `s_udp_hdr_trdy` output 1: header accepted when high with tvalid.
- `s_udp_src_port` input 16: source port.
- `s_udp_dst_port` input 16: destination port.
- `s_udp_length` input 16: UDP length in bytes, header plus payload.
- `s_udp_hdr_checksum` input 16: UDP checksum, transmitted as given.
- `s_axis_tdata` input AXI_DATA_WIDTH: payload byte.
- `s_axis_tvalid` input 1: payload byte valid.
- `s_axis_tlast` input 1: last payload byte.
- `s_axis_trdy` output 1: payload byte accepted.
- `m_axis_tdata` output AXI_DATA_WIDTH: encapsulated frame byte.
- `m_axis_tvalid` output 1: output byte valid.
- `m_axis_tlast` output 1: last byte of frame.
- `m_axis_trdy` input 1: downstream ready.
- `o_len_err` output 1: one-cycle length-mismatch pulse (see Configuration).

## Operation
- States: IDLE, HDR, PAYLOAD, LAST.
- IDLE: `s_udp_hdr_trdy`=1. On `s_udp_hdr_tvalid`&&`s_udp_hdr_trdy`, all four fields are latched, byte index is cleared, header byte 0 is loaded into the output register, and the state goes to HDR.
- HDR: emits header bytes in order src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], csum[15:8], csum[7:0]. A 3-bit index advances on each output handshake. When byte 7 occupies the output register, the state goes to PAYLOAD.
- PAYLOAD: `s_axis_trdy` = !`m_axis_tvalid` || `m_axis_trdy`. Accepted bytes load the output register, and `s_axis_tlast` is copied into `m_axis_tlast`. On an accepted beat with tlast, `s_axis_trdy` drops and the state goes to LAST.
- LAST: waits for output handshake with `m_axis_tlast`=1, then goes to IDLE.
- Output register: holds data stable while `m_axis_tvalid`&&!`m_axis_trdy`. It never drops tvalid without a handshake.
- `m_axis_tlast` is never set on header bytes. The payload must be at least 1 byte.
- `s_udp_hdr_trdy`=0 outside IDLE, and `s_axis_trdy`=0 outside PAYLOAD.
- Header fields are passed through unmodified. No checksum or length arithmetic is done in the datapath.
- Reset (any time, including mid-frame): state goes to IDLE. `m_axis_tvalid`, `m_axis_tlast`, `s_axis_trdy`, `o_len_err` and `m_axis_tdata` go to 0, and `s_udp_hdr_trdy` to 1 after release. A partial frame is abandoned with no tlast.

## Timing
- Header handshake at cycle N: header byte 0 is valid at N+1.
- With `m_axis_trdy` held high: header bytes are on N+1..N+8, `s_axis_trdy` rises at N+8, and payload byte 0 is out at N+9.
- Payload of P bytes with no stalls: tlast byte at N+8+P, and `s_udp_hdr_trdy` returns high at N+9+P. The fixed inter-frame overhead is 1 idle cycle.
- Throughput: 1 byte/cycle in the steady state with no bubbles between header and payload, or inside the payload.
- Downstream stall: all outputs hold, and `s_axis_trdy`=0 while the register is full and `m_axis_trdy`=0.

## Configuration
- `UDP_TX_LEN_CHECK_EN` defined:
  - A 16-bit saturating counter counts accepted payload bytes.
  - At the tlast output handshake, if count+8 != latched length, `o_len_err` pulses high for exactly one cycle.
  - The frame is still transmitted unchanged.
- `UDP_TX_LEN_CHECK_EN` undefined: no counter is built and `o_len_err` is tied to 0.

## Test plan
- Header src=0x1234, dst=0x5678, len=0x000C, csum=0xABCD, payload 01 02 03 04, sink always ready -> output 12 34 56 78 00 0C AB CD 01 02 03 04. tlast only on 04. Header at N+1..N+8, tlast at N+12, hdr_trdy high at N+13.
- Same frame with `m_axis_trdy` toggled 1-0-1-0 -> identical byte sequence, data stable during stalls, no dropped or duplicated bytes.
- Payload source gaps of 3 cycles between bytes -> no `m_axis_tvalid` glitch, correct sequence, tlast on last payload byte.
- Two back-to-back frames, header tvalid held high -> second header accepted 1 cycle after first tlast handshake, second frame correct.
- With `UDP_TX_LEN_CHECK_EN`: len=0x000C and 5-byte payload -> `o_len_err` is a single-cycle pulse at the tlast handshake. With a 4-byte payload, `o_len_err` stays 0.
- Assert reset during header byte 5 -> all outputs 0 within the reset, `s_udp_hdr_trdy`=1 after release, next frame transmitted cleanly from header byte 0.

Source files
------------

// File: rtl/udp_tx.sv
`default_nettype none
// ============================================================================
// Module  : udp_tx
// Brief   : UDP transmit encapsulator. Prepends the 8-byte big-endian UDP
//           header to an AXI-Stream payload. Optional macro
//           UDP_TX_LEN_CHECK_EN adds a payload length check on o_len_err.
// Revision: 1.0 - initial release
// ============================================================================
module udp_tx #(
    parameter int AXI_DATA_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      s_udp_hdr_tvalid,
    output logic                      s_udp_hdr_trdy,
    input  logic [15:0]               s_udp_src_port,
    input  logic [15:0]               s_udp_dst_port,
    input  logic [15:0]               s_udp_length,
    input  logic [15:0]               s_udp_hdr_checksum,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_trdy,
    output logic                      o_len_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        LAST    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [63:0]               hdr_q, hdr_d;
    logic [2:0]                idx_q, idx_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic                      m_hs, s_hs, hdr_hs;

    // Byte i of the header, most significant byte first.
    function automatic logic [7:0] hdr_byte(input logic [63:0] h, input logic [2:0] i);
        logic [63:0] sh;
        sh = h << {i, 3'b000};
        return sh[63:56];
    endfunction

    assign s_udp_hdr_trdy = (state_q == IDLE);
    assign s_axis_trdy    = (state_q == PAYLOAD) && (!valid_q || m_axis_trdy);
    assign m_hs           = valid_q && m_axis_trdy;
    assign s_hs           = s_axis_tvalid && s_axis_trdy;
    assign hdr_hs         = s_udp_hdr_tvalid && s_udp_hdr_trdy;

    assign m_axis_tdata   = data_q;
    assign m_axis_tvalid  = valid_q;
    assign m_axis_tlast   = last_q;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (hdr_hs) begin
                    hdr_d   = {s_udp_src_port, s_udp_dst_port, s_udp_length, s_udp_hdr_checksum};
                    idx_d   = 3'd0;
                    data_d  = s_udp_src_port[15:8];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = HDR;
                end
            end
            HDR: begin
                // Leaving for PAYLOAD as byte 7 enters the register lets the
                // first payload byte follow it without a bubble.
                if (m_hs) begin
                    idx_d  = idx_q + 3'd1;
                    data_d = hdr_byte(hdr_q, idx_q + 3'd1);
                    if (idx_q == 3'd6) begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (m_hs) begin
                    valid_d = 1'b0;
                end
                if (s_hs) begin
                    data_d  = s_axis_tdata;
                    last_d  = s_axis_tlast;
                    valid_d = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                if (m_hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

`ifdef UDP_TX_LEN_CHECK_EN
    logic [15:0] cnt_q, cnt_d;
    logic        len_err_q, len_err_d;

    always_comb begin
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        if (hdr_hs) begin
            cnt_d = '0;
        end else if (s_hs && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        // Compare in 17 bits so a saturated count cannot wrap into a match.
        if ((state_q == LAST) && m_hs &&
            (({1'b0, cnt_q} + 17'd8) != {1'b0, hdr_q[31:16]})) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    assign o_len_err = len_err_q;
`else
    assign o_len_err = 1'b0;
`endif

endmodule
`default_nettype wire
